control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  K&S processor control FSM. Sits beside data_path and drives every data_path enable and select.
//  Consumes decoded_instruction and the registered flags, and issues the RAM write strobe.
//  Multi-cycle sequence per instruction: fetch, decode, execute. Stops permanently on HALT.
// PARAMETERS
//  MEM_WAIT_CYCLES  1  extra RAM wait cycles per access (legal 0..3); each access lasts MEM_WAIT_CYCLES+1 cycles
// PORTS
//  clk                  in   1  clock, rising edge
//  rst_n                in   1  asynchronous active-low reset
//  decoded_instruction  in   decoded_instruction_type  instruction decoded by data_path from IR
//  zero_op              in   1  registered zero flag
//  neg_op               in   1  registered negative flag
//  unsigned_overflow    in   1  registered unsigned overflow flag
//  signed_overflow      in   1  registered signed overflow flag (no branch uses it; reserved)
//  branch               out  1  PC loads mem_addr instead of PC+1
//  pc_enable            out  1  PC update strobe
//  ir_enable            out  1  IR capture strobe
//  addr_sel             out  1  1 = ram_addr from mem_addr, 0 = from PC
//  c_sel                out  1  1 = bus_c from ALU, 0 = from data_in
//  operation            out  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//  write_reg_enable     out  1  register-file write strobe
//  flags_reg_enable     out  1  flags register capture strobe
//  ram_write_enable     out  1  RAM write strobe
//  halt                 out  1  processor halted
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, LOAD, STORE, MOVE, ALU, BRANCH, HALT. 2-bit wait counter wcnt.
//  Outputs are combinational from state, wcnt and inputs. Every output is 0 in IDLE. operation defaults to 00.
//  Reset: async to IDLE with wcnt=0; all outputs 0 while rst_n low. IDLE -> FETCH after 1 cycle.
//  Reset mid-operation: abandons the instruction; no partial strobes; PC re-init is data_path's job.
//  Memory states (FETCH, LOAD, STORE):
//   - Last cycle is the one with wcnt==MEM_WAIT_CYCLES; wcnt increments otherwise.
//   - wcnt clears on state exit. addr_sel is constant for the whole stay.
//  FETCH: addr_sel=0. Last cycle: ir_enable=1, pc_enable=1, branch=0. Then -> DECODE.
//  DECODE: no strobes, 1 cycle. Next state:
//   - LOAD, STORE, MOVE, ALU (ADD/SUB/AND/OR), BRANCH (all 7 branch types)
//   - HALT on I_HALT; FETCH on I_NOP or any unknown value
//  LOAD: addr_sel=1, c_sel=0. Last cycle: write_reg_enable=1. -> FETCH.
//  STORE: addr_sel=1. Last cycle only: ram_write_enable=1 (single-cycle pulse). -> FETCH.
//  MOVE: c_sel=1, operation=11 (a|a), write_reg_enable=1, flags_reg_enable=0. 1 cycle. -> FETCH.
//  ALU: c_sel=1, operation from instruction, write_reg_enable=1, flags_reg_enable=1. 1 cycle. -> FETCH.
//  BRANCH: 1 cycle, condition sampled this cycle.
//   - Taken => pc_enable=1, branch=1; addr_sel=1.
//   - I_BRANCH always taken; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op;
//     BOV unsigned_overflow; BNOV !unsigned_overflow.
//   - Not taken: no strobes. -> FETCH.
//  HALT: halt=1, all strobes 0, absorbing until rst_n low.
//  Latency at MEM_WAIT_CYCLES=N:
//   - FETCH N+1 + DECODE 1 + execute (LOAD/STORE N+1, others 1)
//   - NOP N+2
//  Invariants:
//   - ir_enable and write_reg_enable never high together.
//   - ram_write_enable never high with addr_sel=0.
// CONFIGURATION
//  KS_INSTR_COUNT_EN defined: adds output instr_count[15:0].
//   - Reset 0. +1 on every DECODE exit except to HALT.
//   - Wraps FFFF -> 0000.
//  KS_INSTR_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  k_and_s_pkg gains:
//   - ctrl_state_t enum
//   - ALU op constants OP_ADD/OP_SUB/OP_AND/OP_OR (2-bit)
//  decoded_instruction_type stays in k_and_s_pkg.
//  No sub-module; single always_ff (state, wcnt, counter) plus one always_comb output decoder.
// TESTING
//  MEM_WAIT_CYCLES=0, ADD: FETCH 1 cycle (ir_enable=pc_enable=1), DECODE, ALU (op=00, write_reg_enable=1, flags_reg_enable=1);
//   back in FETCH on cycle 4.
//  MEM_WAIT_CYCLES=2, LOAD: addr_sel=0 for 3 cycles, ir_enable only on 3rd; DECODE;
//   addr_sel=1 for 3 cycles, write_reg_enable only on 3rd; 7 cycles total.
//  STORE, MEM_WAIT_CYCLES=1: ram_write_enable exactly one cycle, on the 2nd STORE cycle, with addr_sel=1.
//  BZERO with zero_op=1 -> pc_enable=branch=1 in BRANCH cycle; zero_op=0 -> no strobes.
//   Repeat for BNNEG (neg_op=0 taken) and BNOV (unsigned_overflow=1 not taken).
//  HALT: halt=1 and all strobes 0 for 20 cycles. rst_n pulse low mid-LOAD (wcnt=1) -> outputs 0 immediately, IDLE then FETCH.
//  KS_INSTR_COUNT_EN: 3 instructions then HALT -> instr_count=3. Preload near wrap: 0xFFFF +1 -> 0x0000.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: decoded instruction set, control FSM states,
// ALU operation codes, and helpers used by the control unit's output decoder.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_LOAD,
      ST_STORE,
      ST_MOVE,
      ST_ALU,
      ST_BRANCH,
      ST_HALT
   } ctrl_state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
      logic [1:0] op;
      op = OP_ADD;
      case (instr)
         I_SUB:   op = OP_SUB;
         I_AND:   op = OP_AND;
         I_OR:    op = OP_OR;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

   // Signed overflow is deliberately absent: no branch in the ISA tests it.
   function automatic logic branch_taken(input decoded_instruction_type instr,
                                         input logic zero, input logic neg,
                                         input logic uovf);
      logic taken;
      taken = 1'b0;
      case (instr)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = zero;
         I_BNZERO: taken = ~zero;
         I_BNEG:   taken = neg;
         I_BNNEG:  taken = ~neg;
         I_BOV:    taken = uovf;
         I_BNOV:   taken = ~uovf;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/control_unit.sv
// K&S control FSM: fetch/decode/execute sequencing and data_path strobes.
// Define KS_INSTR_COUNT_EN to add the 16-bit retired-instruction counter output.
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int MEM_WAIT_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt
`ifdef KS_INSTR_COUNT_EN
   ,
   output logic [15:0]             instr_count
`endif
);

   localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT_CYCLES);

   ctrl_state_t state, next_state;
   logic [1:0]  wcnt, next_wcnt;
   logic        mem_last;
   logic        unused_signed_overflow;

   assign mem_last               = (wcnt == WAIT_LAST);
   assign unused_signed_overflow = signed_overflow;

`ifdef KS_INSTR_COUNT_EN
   logic [15:0] count_q, count_next;
   assign instr_count = count_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         wcnt  <= 2'd0;
`ifdef KS_INSTR_COUNT_EN
         count_q <= 16'd0;
`endif
      end else begin
         state <= next_state;
         wcnt  <= next_wcnt;
`ifdef KS_INSTR_COUNT_EN
         count_q <= count_next;
`endif
      end
   end

   // wcnt only advances inside a memory state that has not reached its last cycle,
   // so every state exit (and every non-memory state) leaves it at zero.
   always_comb begin
      next_state       = state;
      next_wcnt        = 2'd0;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = OP_ADD;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
`ifdef KS_INSTR_COUNT_EN
      count_next       = count_q;
`endif
      case (state)
         ST_IDLE: next_state = ST_FETCH;
         ST_FETCH: begin
            if (mem_last) begin
               ir_enable  = 1'b1;
               pc_enable  = 1'b1;
               next_state = ST_DECODE;
            end else begin
               next_wcnt = wcnt + 2'd1;
            end
         end
         ST_DECODE: begin
            case (decoded_instruction)
               I_LOAD:                          next_state = ST_LOAD;
               I_STORE:                         next_state = ST_STORE;
               I_MOVE:                          next_state = ST_MOVE;
               I_ADD, I_SUB, I_AND, I_OR:       next_state = ST_ALU;
               I_BRANCH, I_BZERO, I_BNZERO,
               I_BNEG, I_BNNEG, I_BOV, I_BNOV:  next_state = ST_BRANCH;
               I_HALT:                          next_state = ST_HALT;
               default:                         next_state = ST_FETCH;
            endcase
`ifdef KS_INSTR_COUNT_EN
            if (decoded_instruction != I_HALT) begin
               count_next = count_q + 16'd1;
            end
`endif
         end
         ST_LOAD: begin
            addr_sel = 1'b1;
            c_sel    = 1'b0;
            if (mem_last) begin
               write_reg_enable = 1'b1;
               next_state       = ST_FETCH;
            end else begin
               next_wcnt = wcnt + 2'd1;
            end
         end
         ST_STORE: begin
            addr_sel = 1'b1;
            if (mem_last) begin
               ram_write_enable = 1'b1;
               next_state       = ST_FETCH;
            end else begin
               next_wcnt = wcnt + 2'd1;
            end
         end
         ST_MOVE: begin
            c_sel            = 1'b1;
            operation        = OP_OR;
            write_reg_enable = 1'b1;
            next_state       = ST_FETCH;
         end
         ST_ALU: begin
            c_sel            = 1'b1;
            operation        = alu_op(decoded_instruction);
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            next_state       = ST_FETCH;
         end
         ST_BRANCH: begin
            if (branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow)) begin
               pc_enable = 1'b1;
               branch    = 1'b1;
               addr_sel  = 1'b1;
            end
            next_state = ST_FETCH;
         end
         ST_HALT: halt = 1'b1;
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: three instances (wait 0/1/2) share inputs, each
// sequence checks the instance whose memory timing it targets.
module tb_control_unit;
   import k_and_s_pkg::*;

   localparam logic [10:0] V_ZERO    = 11'h000;
   localparam logic [10:0] V_FETCH   = 11'h300;
   localparam logic [10:0] V_MEM     = 11'h080;
   localparam logic [10:0] V_LOADWR  = 11'h088;
   localparam logic [10:0] V_STOREWR = 11'h082;
   localparam logic [10:0] V_ADD     = 11'h04C;
   localparam logic [10:0] V_SUB     = 11'h05C;
   localparam logic [10:0] V_MOVE    = 11'h078;
   localparam logic [10:0] V_TAKEN   = 11'h680;
   localparam logic [10:0] V_HALT    = 11'h001;

   logic clk = 1'b0;
   logic rst_n;
   decoded_instruction_type instr;
   logic zero_op, neg_op, uovf, sovf;
   logic [10:0] o0, o1, o2;
   int checks = 0;
   int errors = 0;

`ifdef KS_INSTR_COUNT_EN
   logic [15:0] cnt0, cnt1, cnt2;
`endif

   always #5 clk = ~clk;

   // Output vector bits: branch,pc_enable,ir_enable,addr_sel,c_sel,operation[1:0],
   // write_reg_enable,flags_reg_enable,ram_write_enable,halt
   control_unit #(.MEM_WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
      .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
      .branch(o0[10]), .pc_enable(o0[9]), .ir_enable(o0[8]), .addr_sel(o0[7]), .c_sel(o0[6]),
      .operation(o0[5:4]), .write_reg_enable(o0[3]), .flags_reg_enable(o0[2]),
      .ram_write_enable(o0[1]), .halt(o0[0])
`ifdef KS_INSTR_COUNT_EN
      , .instr_count(cnt0)
`endif
   );

   control_unit #(.MEM_WAIT_CYCLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
      .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
      .branch(o1[10]), .pc_enable(o1[9]), .ir_enable(o1[8]), .addr_sel(o1[7]), .c_sel(o1[6]),
      .operation(o1[5:4]), .write_reg_enable(o1[3]), .flags_reg_enable(o1[2]),
      .ram_write_enable(o1[1]), .halt(o1[0])
`ifdef KS_INSTR_COUNT_EN
      , .instr_count(cnt1)
`endif
   );

   control_unit #(.MEM_WAIT_CYCLES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
      .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
      .branch(o2[10]), .pc_enable(o2[9]), .ir_enable(o2[8]), .addr_sel(o2[7]), .c_sel(o2[6]),
      .operation(o2[5:4]), .write_reg_enable(o2[3]), .flags_reg_enable(o2[2]),
      .ram_write_enable(o2[1]), .halt(o2[0])
`ifdef KS_INSTR_COUNT_EN
      , .instr_count(cnt2)
`endif
   );

   task automatic applyStimulus(input decoded_instruction_type i, input logic z,
                                input logic n, input logic u);
      instr   = i;
      zero_op = z;
      neg_op  = n;
      uovf    = u;
      sovf    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic next;
      @(negedge clk);
   endtask

   // Leaves all instances in their IDLE cycle, sampled mid-cycle.
   task automatic restart(input decoded_instruction_type i, input logic z,
                          input logic n, input logic u);
      rst_n = 1'b0;
      applyStimulus(i, z, n, u);
      next;
      rst_n = 1'b1;
   endtask

   task automatic runBranch(input string tag, input decoded_instruction_type i,
                            input logic z, input logic n, input logic u,
                            input logic [10:0] expected);
      restart(i, z, n, u);
      next;
      next;
      next;
      checkOutput(tag, 16'(o0), 16'(expected));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);
      repeat (2) next;
      checkOutput("reset_u0", 16'(o0), 16'(V_ZERO));
      checkOutput("reset_u1", 16'(o1), 16'(V_ZERO));
      checkOutput("reset_u2", 16'(o2), 16'(V_ZERO));

      // ADD / SUB at zero wait states
      rst_n = 1'b1;
      checkOutput("add_idle", 16'(o0), 16'(V_ZERO));
      next; checkOutput("add_fetch", 16'(o0), 16'(V_FETCH));
      next; checkOutput("add_decode", 16'(o0), 16'(V_ZERO));
      next; checkOutput("add_alu", 16'(o0), 16'(V_ADD));
      next; checkOutput("add_refetch", 16'(o0), 16'(V_FETCH));
      applyStimulus(I_SUB, 1'b0, 1'b0, 1'b0);
      next; checkOutput("sub_decode", 16'(o0), 16'(V_ZERO));
      next; checkOutput("sub_alu", 16'(o0), 16'(V_SUB));
      applyStimulus(I_MOVE, 1'b0, 1'b0, 1'b0);
      next; next; next;
      checkOutput("move_exec", 16'(o0), 16'(V_MOVE));

      // LOAD at two wait states
      restart(I_LOAD, 1'b0, 1'b0, 1'b0);
      checkOutput("load_idle", 16'(o2), 16'(V_ZERO));
      next; checkOutput("load_f1", 16'(o2), 16'(V_ZERO));
      next; checkOutput("load_f2", 16'(o2), 16'(V_ZERO));
      next; checkOutput("load_f3", 16'(o2), 16'(V_FETCH));
      next; checkOutput("load_decode", 16'(o2), 16'(V_ZERO));
      next; checkOutput("load_l1", 16'(o2), 16'(V_MEM));
      next; checkOutput("load_l2", 16'(o2), 16'(V_MEM));
      next; checkOutput("load_l3", 16'(o2), 16'(V_LOADWR));
      next; checkOutput("load_back_fetch", 16'(o2), 16'(V_ZERO));
      next; next; checkOutput("load_next_ir", 16'(o2), 16'(V_FETCH));

      // STORE at one wait state
      restart(I_STORE, 1'b0, 1'b0, 1'b0);
      next; checkOutput("store_f1", 16'(o1), 16'(V_ZERO));
      next; checkOutput("store_f2", 16'(o1), 16'(V_FETCH));
      next; checkOutput("store_decode", 16'(o1), 16'(V_ZERO));
      next; checkOutput("store_s1", 16'(o1), 16'(V_MEM));
      next; checkOutput("store_s2", 16'(o1), 16'(V_STOREWR));
      next; checkOutput("store_after", 16'(o1), 16'(V_ZERO));

      // Branch conditions
      runBranch("bzero_taken",   I_BZERO,  1'b1, 1'b0, 1'b0, V_TAKEN);
      runBranch("bzero_not",     I_BZERO,  1'b0, 1'b0, 1'b0, V_ZERO);
      runBranch("bnneg_taken",   I_BNNEG,  1'b0, 1'b0, 1'b0, V_TAKEN);
      runBranch("bnneg_not",     I_BNNEG,  1'b0, 1'b1, 1'b0, V_ZERO);
      runBranch("bnov_not",      I_BNOV,   1'b0, 1'b0, 1'b1, V_ZERO);
      runBranch("bnov_taken",    I_BNOV,   1'b0, 1'b0, 1'b0, V_TAKEN);
      runBranch("bnzero_taken",  I_BNZERO, 1'b0, 1'b0, 1'b0, V_TAKEN);
      runBranch("bneg_taken",    I_BNEG,   1'b0, 1'b1, 1'b0, V_TAKEN);
      runBranch("bov_taken",     I_BOV,    1'b0, 1'b0, 1'b1, V_TAKEN);
      runBranch("branch_always", I_BRANCH, 1'b0, 1'b0, 1'b0, V_TAKEN);

      // NOP and an undefined encoding both fall straight back to FETCH
      restart(I_NOP, 1'b0, 1'b0, 1'b0);
      next; next;
      checkOutput("nop_decode", 16'(o0), 16'(V_ZERO));
      next; checkOutput("nop_refetch", 16'(o0), 16'(V_FETCH));
      restart(decoded_instruction_type'(5'd31), 1'b0, 1'b0, 1'b0);
      next; next; next;
      checkOutput("unknown_refetch", 16'(o0), 16'(V_FETCH));

      // HALT is absorbing
      restart(I_HALT, 1'b0, 1'b0, 1'b0);
      next; next;
      for (int k = 0; k < 20; k++) begin
         next;
         checkOutput("halt_hold", 16'(o0), 16'(V_HALT));
      end

      // Asynchronous reset in the middle of a LOAD (second cycle, wcnt=1)
      restart(I_LOAD, 1'b0, 1'b0, 1'b0);
      repeat (6) next;
      checkOutput("midload_l2", 16'(o2), 16'(V_MEM));
      #2 rst_n = 1'b0;
      #1 checkOutput("midload_async", 16'(o2), 16'(V_ZERO));
      next;
      rst_n = 1'b1;
      checkOutput("midload_idle", 16'(o2), 16'(V_ZERO));
      next; checkOutput("midload_f1", 16'(o2), 16'(V_ZERO));
      next; checkOutput("midload_f2", 16'(o2), 16'(V_ZERO));
      next; checkOutput("midload_f3", 16'(o2), 16'(V_FETCH));

`ifdef KS_INSTR_COUNT_EN
      // ADD, MOVE, NOP then HALT on the zero-wait instance
      restart(I_ADD, 1'b0, 1'b0, 1'b0);
      checkOutput("count_reset", cnt0, 16'd0);
      next; next; next;
      applyStimulus(I_MOVE, 1'b0, 1'b0, 1'b0);
      next; next; next;
      applyStimulus(I_NOP, 1'b0, 1'b0, 1'b0);
      next; next; next;
      applyStimulus(I_HALT, 1'b0, 1'b0, 1'b0);
      next; next;
      checkOutput("count_three", cnt0, 16'd3);
      repeat (4) next;
      checkOutput("count_halted", cnt0, 16'd3);

      restart(I_NOP, 1'b0, 1'b0, 1'b0);
      next;
      force u0.count_q = 16'hFFFF;
      #1 release u0.count_q;
      next; checkOutput("count_preload", cnt0, 16'hFFFF);
      next; checkOutput("count_wrap", cnt0, 16'h0000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
